// File: rtl/rgb_fpga_line_driver_if.sv
// Bundle of the line handshake, frame-buffer read port and HUB75 panel pins
// shared by the line driver and whatever sits around it.
interface rgb_fpga_line_driver_if #(
  parameter int COLS = 32
);
  localparam int CW = $clog2(COLS);

  logic            enable;
  logic            line_start;
  logic [3:0]      matrix_addr;
  logic            line_rdy;
  logic            mem_rd;
  logic [4+CW-1:0] mem_addr;
  logic [5:0]      mem_data;
  logic            matrix_clk;
  logic            matrix_lat;
  logic            matrix_oe_n;
  logic [3:0]      matrix_row;
  logic [2:0]      rgb_top;
  logic [2:0]      rgb_bot;

  modport master (
    output enable, line_start, matrix_addr, mem_data,
    input  line_rdy, mem_rd, mem_addr, matrix_clk, matrix_lat,
           matrix_oe_n, matrix_row, rgb_top, rgb_bot
  );

  modport slave (
    input  enable, line_start, matrix_addr, mem_data,
    output line_rdy, mem_rd, mem_addr, matrix_clk, matrix_lat,
           matrix_oe_n, matrix_row, rgb_top, rgb_bot
  );
endinterface

// File: rtl/rgb_fpga_line_driver.sv
// Shifts one row of a 1/16-scan HUB75 panel out of the frame buffer, latches
// it, shows it for OE_CYCLES and then answers the controller with line_rdy.
module rgb_fpga_line_driver #(
  parameter int COLS      = 32,
  parameter int CLK_DIV   = 2,
  parameter int OE_CYCLES = 256
) (
  input logic clk,
  input logic rst_n,
  rgb_fpga_line_driver_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = (OE_CYCLES > 1) ? $clog2(OE_CYCLES) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [OW-1:0] OE_LAST  = OW'(OE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_BLANK,
    S_LATCH,
    S_DISPLAY,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DW-1:0]   div_q, div_d;
  logic [OW-1:0]   dcnt_q, dcnt_d;
  logic            line_rdy_q, line_rdy_d;
  logic            mem_rd_q, mem_rd_d;
  logic [4+CW-1:0] mem_addr_q, mem_addr_d;
  logic            matrix_clk_q, matrix_clk_d;
  logic            matrix_lat_q, matrix_lat_d;
  logic            matrix_oe_n_q, matrix_oe_n_d;
  logic [3:0]      matrix_row_q, matrix_row_d;
  logic [2:0]      rgb_top_q, rgb_top_d;
  logic [2:0]      rgb_bot_q, rgb_bot_d;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    div_d        = div_q;
    dcnt_d       = dcnt_q;
    mem_addr_d   = mem_addr_q;
    matrix_row_d = matrix_row_q;
    rgb_top_d    = rgb_top_q;
    rgb_bot_d    = rgb_bot_q;

    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.line_start) begin
            row_d      = bus.matrix_addr;
            col_d      = '0;
            mem_addr_d = {bus.matrix_addr, {CW{1'b0}}};
            state_d    = S_FETCH;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          rgb_top_d = bus.mem_data[5:3];
          rgb_bot_d = bus.mem_data[2:0];
          div_d     = '0;
          state_d   = S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = S_SHIFT_HI;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        // The column counter stops at the last column instead of wrapping.
        S_SHIFT_HI: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (col_q == COL_LAST) begin
              matrix_row_d = row_q;
              state_d      = S_BLANK;
            end else begin
              col_d      = col_q + 1'b1;
              mem_addr_d = {row_q, col_q + 1'b1};
              state_d    = S_FETCH;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_BLANK: state_d = S_LATCH;
        S_LATCH: begin
          dcnt_d  = '0;
          state_d = S_DISPLAY;
        end
        S_DISPLAY: begin
          if (dcnt_q == OE_LAST) state_d = S_DONE;
          else dcnt_d = dcnt_q + 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Pin levels follow the state being entered so they line up with it.
    mem_rd_d      = (state_d == S_FETCH);
    matrix_clk_d  = (state_d == S_SHIFT_HI);
    matrix_lat_d  = (state_d == S_LATCH);
    matrix_oe_n_d = (state_d != S_DISPLAY);
    line_rdy_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      div_q         <= '0;
      dcnt_q        <= '0;
      line_rdy_q    <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      matrix_clk_q  <= 1'b0;
      matrix_lat_q  <= 1'b0;
      matrix_oe_n_q <= 1'b1;
      matrix_row_q  <= '0;
      rgb_top_q     <= '0;
      rgb_bot_q     <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      div_q         <= div_d;
      dcnt_q        <= dcnt_d;
      line_rdy_q    <= line_rdy_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      matrix_clk_q  <= matrix_clk_d;
      matrix_lat_q  <= matrix_lat_d;
      matrix_oe_n_q <= matrix_oe_n_d;
      matrix_row_q  <= matrix_row_d;
      rgb_top_q     <= rgb_top_d;
      rgb_bot_q     <= rgb_bot_d;
    end
  end

  assign bus.line_rdy    = line_rdy_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.matrix_clk  = matrix_clk_q;
  assign bus.matrix_lat  = matrix_lat_q;
  assign bus.matrix_oe_n = matrix_oe_n_q;
  assign bus.matrix_row  = matrix_row_q;
  assign bus.rgb_top     = rgb_top_q;
  assign bus.rgb_bot     = rgb_bot_q;
endmodule

// File: tb/tb_rgb_fpga_line_driver.sv
// Bench for the HUB75 line driver: a default-timing instance and a fast
// instance (CLK_DIV=1, OE_CYCLES=1), each fed by a frame buffer returning the column number.
module tb_rgb_fpga_line_driver;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb_fpga_line_driver_if #(.COLS(32)) bus0 ();
  rgb_fpga_line_driver_if #(.COLS(32)) bus1 ();

  rgb_fpga_line_driver #(.COLS(32), .CLK_DIV(2), .OE_CYCLES(256)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  rgb_fpga_line_driver #(.COLS(32), .CLK_DIV(1), .OE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // Frame buffer: one cycle read latency, word = column number.
  always @(posedge clk) begin
    if (bus0.mem_rd === 1'b1) bus0.mem_data <= 6'(bus0.mem_addr[4:0]);
    if (bus1.mem_rd === 1'b1) bus1.mem_data <= 6'(bus1.mem_addr[4:0]);
  end

  logic [8:0] exp_addr0[$], exp_addr1[$];
  logic [5:0] exp_rgb0[$], exp_rgb1[$];
  logic [8:0] e_addr0, e_addr1, last_addr0, last_addr1;
  logic [5:0] e_rgb0, e_rgb1;
  logic [3:0] exp_row0, exp_row1, prev_row0, prev_row1;
  logic       prev_clk0, prev_clk1;
  int rises0, lats0, oe_low0, rdy_cnt0, rdy_cyc0;
  int rises1, lats1, oe_low1, rdy_cnt1, rdy_cyc1;

  // Scoreboard for the default instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus0.mem_rd === 1'b1) begin
      compared++;
      if (exp_addr0.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL addr0: unexpected read of %h, no read required", bus0.mem_addr);
      end else begin
        e_addr0 = exp_addr0.pop_front();
        if (bus0.mem_addr !== e_addr0) begin
          mismatched++;
          $display("[TB] FAIL addr0: got %h want %h", bus0.mem_addr, e_addr0);
        end
      end
      last_addr0 = bus0.mem_addr;
    end
    if (prev_clk0 === 1'b0 && bus0.matrix_clk === 1'b1) begin
      rises0++;
      compared++;
      e_rgb0 = (exp_rgb0.size() != 0) ? exp_rgb0.pop_front() : 6'h3f;
      if ({bus0.rgb_top, bus0.rgb_bot} !== e_rgb0) begin
        mismatched++;
        $display("[TB] FAIL rgb0: got %h want %h", {bus0.rgb_top, bus0.rgb_bot}, e_rgb0);
      end
    end
    if (bus0.matrix_lat === 1'b1) begin
      lats0++;
      compared++;
      if (prev_row0 !== exp_row0 || bus0.matrix_row !== exp_row0) begin
        mismatched++;
        $display("[TB] FAIL row0: got %h/%h want %h", prev_row0, bus0.matrix_row, exp_row0);
      end
    end
    if (bus0.matrix_oe_n === 1'b0) oe_low0++;
    if (bus0.line_rdy === 1'b1) begin
      rdy_cnt0++;
      rdy_cyc0 = cyc;
    end
    prev_clk0 = bus0.matrix_clk;
    prev_row0 = bus0.matrix_row;
  end

  // Same scoreboard for the fast instance.
  always @(negedge clk) begin
    if (bus1.mem_rd === 1'b1) begin
      compared++;
      if (exp_addr1.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL addr1: unexpected read of %h, no read required", bus1.mem_addr);
      end else begin
        e_addr1 = exp_addr1.pop_front();
        if (bus1.mem_addr !== e_addr1) begin
          mismatched++;
          $display("[TB] FAIL addr1: got %h want %h", bus1.mem_addr, e_addr1);
        end
      end
      last_addr1 = bus1.mem_addr;
    end
    if (prev_clk1 === 1'b0 && bus1.matrix_clk === 1'b1) begin
      rises1++;
      compared++;
      e_rgb1 = (exp_rgb1.size() != 0) ? exp_rgb1.pop_front() : 6'h3f;
      if ({bus1.rgb_top, bus1.rgb_bot} !== e_rgb1) begin
        mismatched++;
        $display("[TB] FAIL rgb1: got %h want %h", {bus1.rgb_top, bus1.rgb_bot}, e_rgb1);
      end
    end
    if (bus1.matrix_lat === 1'b1) begin
      lats1++;
      compared++;
      if (prev_row1 !== exp_row1 || bus1.matrix_row !== exp_row1) begin
        mismatched++;
        $display("[TB] FAIL row1: got %h/%h want %h", prev_row1, bus1.matrix_row, exp_row1);
      end
    end
    if (bus1.matrix_oe_n === 1'b0) oe_low1++;
    if (bus1.line_rdy === 1'b1) begin
      rdy_cnt1++;
      rdy_cyc1 = cyc;
    end
    prev_clk1 = bus1.matrix_clk;
    prev_row1 = bus1.matrix_row;
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clear_stats();
    rises0 = 0; lats0 = 0; oe_low0 = 0; rdy_cnt0 = 0; rdy_cyc0 = -1;
    rises1 = 0; lats1 = 0; oe_low1 = 0; rdy_cnt1 = 0; rdy_cyc1 = -1;
    exp_addr0.delete(); exp_rgb0.delete();
    exp_addr1.delete(); exp_rgb1.delete();
  endtask

  // Drives a one-cycle line_start; s is the cycle in which it is high.
  task automatic start_line(input int which, input logic [3:0] row, output int s);
    @(negedge clk);
    s = cyc;
    for (int c = 0; c < 32; c++) begin
      if (which == 0) begin
        exp_addr0.push_back({row, 5'(c)});
        exp_rgb0.push_back(6'(c));
      end else begin
        exp_addr1.push_back({row, 5'(c)});
        exp_rgb1.push_back(6'(c));
      end
    end
    if (which == 0) begin
      exp_row0 = row; bus0.matrix_addr = row; bus0.line_start = 1'b1;
    end else begin
      exp_row1 = row; bus1.matrix_addr = row; bus1.line_start = 1'b1;
    end
    @(negedge clk);
    bus0.line_start = 1'b0;
    bus1.line_start = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [23:0] got0, got1;
    logic [23:0] want;
    want = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 4'h0, 3'h0, 3'h0};
    rst_n = 1'b0;
    bus0.enable = 1'b1; bus0.line_start = 1'b0; bus0.matrix_addr = 4'h0;
    bus1.enable = 1'b1; bus1.line_start = 1'b0; bus1.matrix_addr = 4'h0;
    repeat (3) @(negedge clk);
    got0 = {bus0.line_rdy, bus0.mem_rd, bus0.matrix_clk, bus0.matrix_lat, bus0.matrix_oe_n,
            bus0.mem_addr, bus0.matrix_row, bus0.rgb_top, bus0.rgb_bot};
    got1 = {bus1.line_rdy, bus1.mem_rd, bus1.matrix_clk, bus1.matrix_lat, bus1.matrix_oe_n,
            bus1.mem_addr, bus1.matrix_row, bus1.rgb_top, bus1.rgb_bot};
    compared++;
    if (got0 !== want) begin
      mismatched++;
      $display("[TB] FAIL reset0: got %h want %h", got0, want);
    end
    compared++;
    if (got1 !== want) begin
      mismatched++;
      $display("[TB] FAIL reset1: got %h want %h", got1, want);
    end
    compared++;
    if (bus0.matrix_oe_n !== 1'b1 || bus0.mem_rd !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_oe: got oe_n=%b mem_rd=%b want 1/0", bus0.matrix_oe_n, bus0.mem_rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_line();
    int s;
    clear_stats();
    start_line(0, 4'd5, s);
    wait_until(s + 460);
    check_int("full_rdy_count", rdy_cnt0, 1);
    check_int("full_rdy_cycle", rdy_cyc0, s + 451);
    check_int("full_clk_rises", rises0, 32);
    check_int("full_latches", lats0, 1);
    check_int("full_oe_cycles", oe_low0, 256);
    check_int("full_last_addr", int'(last_addr0), 'h0BF);
    check_int("full_reads_left", exp_addr0.size(), 0);
  endtask

  task automatic test_ignored_start();
    int s;
    clear_stats();
    start_line(0, 4'd5, s);
    wait_until(s + 100);
    bus0.matrix_addr = 4'd9;
    bus0.line_start = 1'b1;
    @(negedge clk);
    bus0.line_start = 1'b0;
    wait_until(s + 470);
    check_int("ignored_rdy_count", rdy_cnt0, 1);
    check_int("ignored_rdy_cycle", rdy_cyc0, s + 451);
    check_int("ignored_clk_rises", rises0, 32);
  endtask

  task automatic test_enable_abort();
    int s, s2;
    clear_stats();
    start_line(0, 4'd3, s);
    wait_until(s + 50);
    bus0.enable = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus0.matrix_oe_n, bus0.mem_rd, bus0.matrix_clk, bus0.matrix_lat} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL abort_pins: got %b want 1000",
               {bus0.matrix_oe_n, bus0.mem_rd, bus0.matrix_clk, bus0.matrix_lat});
    end
    exp_addr0.delete(); exp_rgb0.delete();
    wait_until(s + 55);
    bus0.enable = 1'b1;
    wait_until(s + 59);
    check_int("abort_no_rdy", rdy_cnt0, 0);
    clear_stats();
    start_line(0, 4'd6, s2);
    wait_until(s2 + 460);
    check_int("abort_restart_cycle", s2, s + 60);
    check_int("abort_rdy_count", rdy_cnt0, 1);
    check_int("abort_rdy_cycle", rdy_cyc0, s + 60 + 451);
    check_int("abort_clk_rises", rises0, 32);
  endtask

  task automatic test_fast();
    int s;
    clear_stats();
    start_line(1, 4'd15, s);
    wait_until(s + 140);
    check_int("fast_rdy_count", rdy_cnt1, 1);
    check_int("fast_rdy_cycle", rdy_cyc1, s + 132);
    check_int("fast_last_addr", int'(last_addr1), 'h1FF);
    check_int("fast_clk_rises", rises1, 32);
    check_int("fast_latches", lats1, 1);
    check_int("fast_oe_cycles", oe_low1, 1);
  endtask

  task automatic test_reset_display();
    int s, s2;
    clear_stats();
    start_line(0, 4'd2, s);
    wait_until(s + 300);
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus0.matrix_oe_n, bus0.line_rdy, bus0.matrix_lat, bus0.matrix_row,
         bus0.rgb_top, bus0.rgb_bot} !== {1'b1, 1'b0, 1'b0, 4'h0, 6'h00}) begin
      mismatched++;
      $display("[TB] FAIL rst_display: got oe_n=%b rdy=%b lat=%b row=%h rgb=%h want 1/0/0/0/00",
               bus0.matrix_oe_n, bus0.line_rdy, bus0.matrix_lat, bus0.matrix_row,
               {bus0.rgb_top, bus0.rgb_bot});
    end
    rst_n = 1'b1;
    wait_until(s + 470);
    check_int("rst_display_no_rdy", rdy_cnt0, 0);
    clear_stats();
    start_line(0, 4'd7, s2);
    wait_until(s2 + 460);
    check_int("rst_display_next_rdy", rdy_cyc0, s2 + 451);
    check_int("rst_display_next_count", rdy_cnt0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.enable = 1'b0; bus0.line_start = 1'b0; bus0.matrix_addr = 4'h0;
    bus1.enable = 1'b0; bus1.line_start = 1'b0; bus1.matrix_addr = 4'h0;
    clear_stats();
    test_reset();
    test_full_line();
    test_ignored_start();
    test_enable_abort();
    test_fast();
    test_reset_display();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rgb_fpga_line_driver.md
# rgb_fpga_line_driver

Per-line shift-out engine for a HUB75-style 32-column, 1/16-scan RGB LED matrix. It answers the display controller's line handshake. On `line_start` it captures `matrix_addr` and reads one row's pixel words from the frame buffer. It shifts the pixels into the panel, latches them, drives the row address, and displays the row for a fixed time. It then pulses `line_rdy` back to the display controller.

## Interface
- `COLS`, 32: columns per row; power of two, ≥ 2.
- `CLK_DIV`, 2: system cycles per half period of `matrix_clk`; ≥ 1.
- `OE_CYCLES`, 256: cycles the row is displayed (`matrix_oe_n` low); ≥ 1.
- Derived `CW` = $clog2(COLS).
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `enable`  in  1  block enable; low aborts any line in progress.
- `line_start`  in  1  single-cycle request to output one row.
- `matrix_addr`  in  4  row to output; sampled with `line_start`.
- `line_rdy`  out  1  single-cycle pulse when the row's display time has ended.
- `mem_rd`  out  1  frame-buffer read strobe.
- `mem_addr`  out  4+CW  read address {row, column}.
- `mem_data`  in  6  {r1,g1,b1,r2,g2,b2}; valid the cycle after `mem_rd`.
- `matrix_clk`  out  1  panel shift clock.
- `matrix_lat`  out  1  panel latch.
- `matrix_oe_n`  out  1  panel output enable, active low.
- `matrix_row`  out  4  panel row address A–D.
- `rgb_top`  out  3  {r1,g1,b1}, upper half of the panel.
- `rgb_bot`  out  3  {r2,g2,b2}, lower half of the panel.

## Operation
- All outputs are registered. Reset values: `line_rdy`, `mem_rd`, `matrix_clk` and `matrix_lat` = 0; `matrix_oe_n` = 1; `mem_addr`, `matrix_row`, `rgb_top` and `rgb_bot` = 0. State = IDLE, column counter = 0.
- Internal registers:
  - `row_q` (4 bit) holds the captured row.
  - `col` (CW bit) is the column counter; it does not wrap inside a line.
  - `div` counts `CLK_DIV` cycles.
  - `dcnt` counts `OE_CYCLES`.
- FSM states:
  - IDLE: `matrix_oe_n` = 1. If `enable` and `line_start`: `row_q` ← `matrix_addr`, `col` ← 0, go to FETCH. Otherwise stay.
  - FETCH (1 cycle): `mem_rd` = 1, `mem_addr` = {`row_q`, `col`}, `matrix_clk` = 0. Go to WAIT.
  - WAIT (1 cycle): `mem_data` is valid; capture it into `rgb_top`/`rgb_bot` at the end of the cycle. Go to SHIFT_LO.
  - SHIFT_LO (`CLK_DIV` cycles): `matrix_clk` = 0, RGB stable. Go to SHIFT_HI.
  - SHIFT_HI (`CLK_DIV` cycles): `matrix_clk` = 1, RGB stable. If `col` = COLS−1, go to BLANK. Otherwise `col`+1 and go to FETCH.
  - BLANK (1 cycle): `matrix_clk` = 0, `matrix_row` ← `row_q`. Go to LATCH.
  - LATCH (1 cycle): `matrix_lat` = 1. Go to DISPLAY.
  - DISPLAY (`OE_CYCLES` cycles): `matrix_oe_n` = 0. Go to DONE.
  - DONE (1 cycle): `line_rdy` = 1, `matrix_oe_n` = 1. Go to IDLE.
- `matrix_oe_n` is 1 in every state except DISPLAY. Panels are blanked while shifting (no ghosting).
- `line_start` outside IDLE is ignored; no queueing.
- `enable` low in any state: next state is IDLE. `matrix_clk`, `matrix_lat` and `mem_rd` go to 0 and `matrix_oe_n` goes to 1. No `line_rdy` is issued. `matrix_row` and RGB keep their values.
- `enable` and `line_start` both asserted in the same cycle in IDLE: the line starts.
- Reset asserted mid-line: on the next edge all outputs take their reset values and the FSM enters IDLE; no `line_rdy`.

## Timing
- Per column: 2 + 2·`CLK_DIV` cycles (6 at defaults).
- Line latency: `line_start` is high in cycle S. FETCH of column 0 is in S+1. `line_rdy` is high in cycle S+1+COLS·(2+2·CLK_DIV)+2+OE_CYCLES. At defaults that is S+451.
- Panel setup/hold: RGB changes only at the end of WAIT. `matrix_clk` rises `CLK_DIV` cycles later and falls `CLK_DIV` cycles after rising. This gives ≥ `CLK_DIV` cycles of setup and ≥ `CLK_DIV` cycles of hold.
- `matrix_lat` pulses exactly once per line, 1 cycle after the last `matrix_clk` falling edge. `matrix_row` is stable 1 cycle before `matrix_lat`.
- Exactly COLS rising edges of `matrix_clk` per completed line.

## Test plan
- Reset, hold `rst_n` = 0 for 3 cycles -> all outputs at reset values, `matrix_oe_n` = 1, no `mem_rd`.
- Memory model returns word = column number. `line_start` with `matrix_addr` = 5, defaults -> `mem_addr` sequence 0xA0..0xBF, 32 `matrix_clk` rises, RGB equal to the column's data at each rise, `matrix_row` = 5 before `matrix_lat`, 256 cycles of `matrix_oe_n` = 0, `line_rdy` at S+451.
- `line_start` pulsed again at S+100 -> ignored; only one `line_rdy` at S+451.
- `enable` dropped at S+50 -> IDLE at S+51, `matrix_oe_n` = 1, no `line_rdy`. A new `line_start` at S+60 completes normally at S+60+451.
- `matrix_addr` = 15, `CLK_DIV` = 1, `OE_CYCLES` = 1 -> `line_rdy` at S+1+32·4+3 = S+132; last `mem_addr` = 0x1FF.
- `rst_n` low during DISPLAY -> `matrix_oe_n` = 1 the next cycle, no `line_rdy`, FSM idle.
